// File: rtl/int_ctrl_pkg.sv
// Shared constants, cell state type and byte-lane merge helper for int_ctrl.
package int_ctrl_pkg;

  localparam logic [31:0] OFF_PEND = 32'h00;
  localparam logic [31:0] OFF_MASK = 32'h04;
  localparam logic [31:0] OFF_EDGE = 32'h08;
  localparam logic [31:0] OFF_PCM  = 32'h0C;
  localparam logic [31:0] OFF_STAT = 32'h10;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } cell_state_e;

  function automatic logic [31:0] merge_be(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/int_src_cell.sv
// One interrupt source: edge/level event detection, pending latch and overflow flag.
module int_src_cell
  import int_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic src,
  input  logic edge_mode,
  input  logic clr,
  input  logic inj,
  output logic pending,
  output logic ovf
);

  cell_state_e state_q;
  logic        prev_q;
  logic        ovf_q;
  logic        src_evt;
  logic        set_evt;

  assign src_evt = edge_mode ? (src & ~prev_q) : src;
  assign set_evt = src_evt | inj;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      prev_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      prev_q <= src;
      if (clr) ovf_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (set_evt) state_q <= PENDING;
        end
        PENDING: begin
          // A new edge while still pending is remembered as overflow; it wins over a clear.
          if (edge_mode && src_evt) ovf_q <= 1'b1;
          if (clr && !set_evt) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pending = (state_q == PENDING);
  assign ovf     = ovf_q;

endmodule

// File: rtl/int_ctrl.sv
// Memory-mapped interrupt controller feeding CP0 HWInt.
// Optional PC-match injector enabled by defining INT_CTRL_PCMATCH_EN.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h0000_7f20,
  parameter int          NSRC      = 6,
  parameter int          INJ_BIT   = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_src,
  input  logic [31:0]     macroscopic_pc,
  input  logic [31:0]     bus_addr,
  input  logic [31:0]     bus_wdata,
  input  logic [3:0]      bus_byteen,
  output logic [31:0]     bus_rdata,
  output logic [NSRC-1:0] hwint
);

  logic [NSRC-1:0] mask_q, edge_q;
  logic [NSRC-1:0] pend, ovf, clr_v, inj_v;
  logic [31:0]     off, off_w, mask_wr, edge_wr, pcm_rd, status;
  logic            wr, sel_pend, sel_mask, sel_edge, sel_pcm, sel_stat;
  logic [2:0]      idx;
  logic            hit;

  assign off      = bus_addr - ADDR_BASE;
  assign off_w    = {off[31:2], 2'b00};
  assign wr       = |bus_byteen;
  assign sel_pend = (off_w == OFF_PEND);
  assign sel_mask = (off_w == OFF_MASK);
  assign sel_edge = (off_w == OFF_EDGE);
  assign sel_pcm  = (off_w == OFF_PCM);
  assign sel_stat = (off_w == OFF_STAT);

  assign clr_v   = (wr && sel_pend && bus_byteen[0]) ? bus_wdata[NSRC-1:0] : '0;
  assign mask_wr = merge_be(32'(mask_q), bus_wdata, bus_byteen);
  assign edge_wr = merge_be(32'(edge_q), bus_wdata, bus_byteen);

`ifdef INT_CTRL_PCMATCH_EN
  logic [31:0] pcm_q;
  logic [31:0] pcm_wr;
  logic        unused_ok;

  assign pcm_wr    = merge_be(pcm_q, bus_wdata, bus_byteen);
  assign hit       = pcm_q[0] && (macroscopic_pc[31:2] == pcm_q[31:2]);
  assign pcm_rd    = pcm_q;
  assign unused_ok = ^{macroscopic_pc[1:0], off[1:0], mask_wr[31:NSRC], edge_wr[31:NSRC]};

  // A software write in the hit cycle wins, so re-arming is never lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      pcm_q <= '0;
    end else if (wr && sel_pcm) begin
      pcm_q <= pcm_wr & 32'hFFFF_FFFD;
    end else if (hit) begin
      pcm_q[0] <= 1'b0;
    end
  end
`else
  logic unused_ok;

  assign hit       = 1'b0;
  assign pcm_rd    = '0;
  assign unused_ok = ^{macroscopic_pc, off[1:0], mask_wr[31:NSRC], edge_wr[31:NSRC]};
`endif

  always_comb begin
    inj_v          = '0;
    inj_v[INJ_BIT] = hit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q <= '1;
      edge_q <= '0;
    end else begin
      if (wr && sel_mask) mask_q <= mask_wr[NSRC-1:0];
      if (wr && sel_edge) edge_q <= edge_wr[NSRC-1:0];
    end
  end

  for (genvar i = 0; i < NSRC; i++) begin : g_cell
    int_src_cell u_cell (
      .clk       (clk),
      .reset     (reset),
      .src       (irq_src[i]),
      .edge_mode (edge_q[i]),
      .clr       (clr_v[i]),
      .inj       (inj_v[i]),
      .pending   (pend[i]),
      .ovf       (ovf[i])
    );
  end

  assign hwint = pend & mask_q;

  // Lowest-numbered active source has priority.
  always_comb begin
    idx = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (hwint[i]) idx = 3'(i);
    end
  end

  assign status = {16'h0, 8'(ovf), 4'h0, idx, |hwint};

  always_comb begin
    bus_rdata = '0;
    if (sel_pend)      bus_rdata = 32'(pend);
    else if (sel_mask) bus_rdata = 32'(mask_q);
    else if (sel_edge) bus_rdata = 32'(edge_q);
    else if (sel_pcm)  bus_rdata = pcm_rd;
    else if (sel_stat) bus_rdata = status;
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed self-checking bench for int_ctrl.
module tb_int_ctrl;

  localparam logic [31:0] BASE  = 32'h0000_7f20;
  localparam logic [31:0] A_PND = BASE + 32'h00;
  localparam logic [31:0] A_MSK = BASE + 32'h04;
  localparam logic [31:0] A_EDG = BASE + 32'h08;
  localparam logic [31:0] A_PCM = BASE + 32'h0C;
  localparam logic [31:0] A_STA = BASE + 32'h10;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  irq_src;
  logic [31:0] macroscopic_pc;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_byteen;
  logic [31:0] bus_rdata;
  logic [5:0]  hwint;

  int checks = 0;
  int errors = 0;

  int_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .irq_src        (irq_src),
    .macroscopic_pc (macroscopic_pc),
    .bus_addr       (bus_addr),
    .bus_wdata      (bus_wdata),
    .bus_byteen     (bus_byteen),
    .bus_rdata      (bus_rdata),
    .hwint          (hwint)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs change at the negedge, outputs settle by posedge+1.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] be);
    @(negedge clk);
    bus_addr   = addr;
    bus_wdata  = data;
    bus_byteen = be;
    @(posedge clk);
    #1;
    bus_byteen = 4'h0;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    bus_addr   = addr;
    bus_byteen = 4'h0;
    #1;
    data = bus_rdata;
  endtask

  task automatic set_src(input logic [5:0] v);
    @(negedge clk);
    irq_src = v;
  endtask

  task automatic check_reg(input string name, input logic [31:0] addr,
                           input logic [31:0] exp);
    logic [31:0] got;
    bus_read(addr, got);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_hw(input string name, input logic [5:0] exp);
    checks++;
    if (hwint !== exp) begin
      errors++;
      $display("FAIL %s: hwint got %b expected %b", name, hwint, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    irq_src = '0;
    macroscopic_pc = '0;
    bus_addr = '0;
    bus_wdata = '0;
    bus_byteen = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_hw("reset_hwint", 6'h00);
    check_reg("reset_pend", A_PND, 32'h0);
    check_reg("reset_mask", A_MSK, 32'h3f);
    check_reg("reset_edge", A_EDG, 32'h0);
    check_reg("reset_pcm", A_PCM, 32'h0);
    check_reg("reset_stat", A_STA, 32'h0);
    check_reg("reset_outside", BASE + 32'h14, 32'h0);
  endtask

  task automatic test_level_mask();
    set_src(6'b000100);
    #1;
    check_hw("level_before_edge", 6'h00);
    tick();
    check_hw("level_latched", 6'b000100);
    bus_write(A_MSK, 32'h3b, 4'hF);
    check_hw("level_masked", 6'h00);
    check_reg("level_masked_pend", A_PND, 32'h04);
    bus_write(A_MSK, 32'h3f, 4'hF);
    check_hw("level_unmasked", 6'b000100);
    // Source still high: clear is overridden by the same-cycle level event.
    bus_write(A_PND, 32'h04, 4'h1);
    check_reg("level_repend", A_PND, 32'h04);
    set_src(6'b000000);
    bus_write(A_PND, 32'h04, 4'h1);
    check_reg("level_cleared", A_PND, 32'h0);
  endtask

  task automatic test_partial();
    bus_write(A_MSK, 32'h0000_0000, 4'b0010);
    check_reg("partial_mask", A_MSK, 32'h3f);
    bus_write(A_EDG, 32'h0000_0015, 4'b0001);
    check_reg("partial_edge_lane0", A_EDG, 32'h15);
    bus_write(A_EDG, 32'h0000_0000, 4'b0001);
    set_src(6'b000010);
    tick();
    set_src(6'b000000);
    bus_write(A_PND, 32'h0000_FF02, 4'b0010);
    check_reg("partial_pend_lane1", A_PND, 32'h02);
    bus_write(A_PND, 32'h02, 4'h1);
    check_reg("partial_pend_lane0", A_PND, 32'h0);
  endtask

  task automatic test_edge_ovf();
    bus_write(A_EDG, 32'h01, 4'hF);
    set_src(6'b000001);
    tick();
    check_reg("edge_first", A_PND, 32'h01);
    // Held high: no new edge, clear sticks.
    bus_write(A_PND, 32'h01, 4'h1);
    check_reg("edge_held_clear", A_PND, 32'h0);
    set_src(6'b000000);
    set_src(6'b000001);
    tick();
    set_src(6'b000000);
    set_src(6'b000001);
    tick();
    set_src(6'b000000);
    #1;
    check_reg("edge_ovf_pend", A_PND, 32'h01);
    check_reg("edge_ovf_stat", A_STA, 32'h0101);
    bus_write(A_PND, 32'h01, 4'h1);
    check_reg("edge_ack_pend", A_PND, 32'h0);
    check_reg("edge_ack_stat", A_STA, 32'h0);
  endtask

  task automatic test_collision();
    bus_write(A_EDG, 32'h02, 4'hF);
    @(negedge clk);
    irq_src    = 6'b000010;
    bus_addr   = A_PND;
    bus_wdata  = 32'h02;
    bus_byteen = 4'h1;
    tick();
    bus_byteen = 4'h0;
    check_reg("collision_set_wins", A_PND, 32'h02);
    bus_write(A_PND, 32'h02, 4'h1);
    check_reg("collision_later_clear", A_PND, 32'h0);
    set_src(6'b000000);
    bus_write(A_EDG, 32'h0, 4'hF);
  endtask

  task automatic test_priority();
    set_src(6'b101000);
    tick();
    set_src(6'b000000);
    #1;
    check_reg("prio_pend", A_PND, 32'h28);
    check_reg("prio_stat", A_STA, 32'h07);
    bus_write(A_PND, 32'h08, 4'h1);
    check_reg("prio_stat_next", A_STA, 32'h0b);
    bus_write(A_PND, 32'h20, 4'h1);
    check_reg("prio_stat_empty", A_STA, 32'h0);
    check_hw("prio_hwint_empty", 6'h00);
  endtask

  task automatic test_injector();
`ifdef INT_CTRL_PCMATCH_EN
    bus_write(A_PCM, 32'h300d, 4'hF);
    check_reg("inj_armed", A_PCM, 32'h300d);
    @(negedge clk);
    macroscopic_pc = 32'h300c;
    tick();
    @(negedge clk);
    macroscopic_pc = 32'h3010;
    #1;
    check_hw("inj_hit", 6'b000100);
    check_reg("inj_disarmed", A_PCM, 32'h300c);
    bus_write(A_PND, 32'h04, 4'h1);
    check_hw("inj_ack", 6'h00);
    @(negedge clk);
    macroscopic_pc = 32'h300e;
    tick();
    tick();
    check_hw("inj_one_shot", 6'h00);
`else
    bus_write(A_PCM, 32'h300d, 4'hF);
    check_reg("pcm_absent", A_PCM, 32'h0);
    @(negedge clk);
    macroscopic_pc = 32'h300c;
    tick();
    tick();
    check_hw("pcm_no_inject", 6'h00);
`endif
  endtask

  task automatic test_reset_edge();
    bus_write(A_EDG, 32'h10, 4'hF);
    @(negedge clk);
    reset   = 1'b1;
    irq_src = 6'b010000;
    tick();
    check_hw("reset_hold_quiet", 6'h00);
    @(negedge clk);
    reset = 1'b0;
    tick();
    check_hw("reset_release_edge", 6'b010000);
    set_src(6'b000000);
  endtask

  initial begin
    test_reset();
    test_level_mask();
    test_partial();
    test_edge_ovf();
    test_collision();
    test_priority();
    test_injector();
    test_reset_edge();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
# int_ctrl

Memory-mapped interrupt controller between the P7 peripherals (timers, external interrupt generator) and the CPU's CP0 `HWInt` inputs. It latches six device requests as pending bits, applies per-source mask and edge/level mode, and presents the masked vector to CP0. Handlers acknowledge a request with a store into its register window at 0x7f20. An optional PC-match injector raises a one-shot request when the macroscopic PC reaches a programmed address, for deterministic interrupt testing.

## Interface
- `ADDR_BASE`, 32'h0000_7f20: word-aligned base of the 5-word register window.
- `NSRC`, 6: number of sources; must be ≤ 8.
- `INJ_BIT`, 2: pending bit set by the PC-match injector.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `irq_src` in NSRC: raw device requests; bit i is source i.
- `macroscopic_pc` in 32: committed PC from the CPU. Bits [1:0] are ignored.
- `bus_addr` in 32: CPU data address.
- `bus_wdata` in 32: CPU store data.
- `bus_byteen` in 4: store byte enables. Any nonzero value means a write.
- `bus_rdata` out 32: read data for `bus_addr`. Combinational from registers.
- `hwint` out NSRC: `pend & mask`, driven from registers.

## Operation
Register map, word offsets from `ADDR_BASE`:
- +0x0 PEND: read returns `pend`. A write with `byteen[0]=1` clears each bit i where `wdata[i]=1` (write-1-to-clear). The same write also clears the matching OVF bits.
- +0x4 MASK: read/write. Reset value is all ones.
- +0x8 EDGE: read/write. Bit=1 selects rising-edge mode; bit=0 selects level mode. Reset value is 0.
- +0xC PCMATCH: bit 0 is ARM; bits [31:2] are the target PC. A write loads both fields.
- +0x10 STATUS, read-only: [0] = any `hwint`; [3:1] = index of lowest-numbered active `hwint` (0 if none); [15:8] = OVF.
- Other addresses, including words outside the window, read 0 and ignore writes.
- Partial writes update only the enabled byte lanes, except PEND, which acts on lane 0 only.

Per-source cell, state {IDLE, PENDING}:
- Event, edge mode: `irq_src[i]` is 1 and `prev_src[i]` is 0. `prev_src` is a registered copy of `irq_src`.
- Event, level mode: `irq_src[i]` is 1.
- IDLE → PENDING on an event.
- PENDING → IDLE on a W1C clear for bit i, unless an event occurs in the same cycle. Set wins, so an event is never lost.
- An edge-mode event while already PENDING sets OVF[i] and leaves PENDING unchanged.
- Level mode never sets OVF. A level source that is still high re-pends on the next cycle after a clear.
- Mask does not gate latching. A masked source still goes pending and becomes visible in `hwint` when it is unmasked.

## Timing
- Reset values:
  - `pend`, OVF, EDGE, `prev_src`, PCMATCH: 0.
  - MASK: all ones.
  - `hwint`: 0.
  - `bus_rdata`: follows the registers, so it reads reset values.
- Source to `hwint`: an event sampled at edge N appears on `hwint` after edge N (1-cycle latency).
- Write to `hwint`: a W1C or MASK write at edge N takes effect on `hwint` after edge N.
- Reads have zero latency. A read and a write to the same register in one cycle returns the pre-write value.
- Edge detection does not register an event while `reset=1`. `prev_src` reloads to 0, so a source that is high when reset is released counts as an edge on the first cycle.

## Configuration
- Macro: `INT_CTRL_PCMATCH_EN`.
- Defined:
  - While ARM=1 and `(macroscopic_pc & ~3) == {PCMATCH[31:2],2'b00}`, the block sets `pend[INJ_BIT]` at the next edge and clears ARM (one-shot).
  - An injector hit and a W1C clear of `INJ_BIT` in the same cycle: set wins.
  - A software write that re-arms in the same cycle as a hit: the write wins and ARM stays 1.
- Undefined: PCMATCH reads 0, writes are ignored, and no injection logic is generated.

## Structure
- `int_ctrl_pkg` holds:
  - register offset constants `OFF_PEND`, `OFF_MASK`, `OFF_EDGE`, `OFF_PCM`, `OFF_STAT`;
  - the cell state enum {IDLE, PENDING}.
- Sub-module `int_src_cell`, instantiated NSRC times. Ports:
  - inputs: `src`, `edge_mode`, `clr`, `inj`;
  - outputs: `pending`, `ovf`.
- The top level holds the register file, address decode, STATUS encoder and the injector.

## Test plan
- Reset then idle: `hwint=0`, MASK reads 0x3f, all other registers read 0.
- Level source and mask: hold `irq_src=6'b000100` → `hwint=6'b000100` one cycle later. Write MASK=0x3b → `hwint=0` while PEND still reads 0x04. Write MASK=0x3f → `hwint` returns to 0x04.
- Edge mode and overflow: EDGE=0x01, pulse `irq_src[0]` twice with no ack between → PEND=0x01 and STATUS[15:8]=0x01. W1C wdata=0x01 → PEND=0 and OVF=0.
- Set-vs-clear collision: EDGE=0x02, a `irq_src[1]` rising edge in the same cycle as W1C 0x02 → PEND[1] stays 1.
- Priority: pend sources 5 and 3 → STATUS=0x7 (index 3, any=1).
- Injector (`INT_CTRL_PCMATCH_EN`): write PCMATCH=0x300d (target 0x300c, ARM=1). When the PC reaches 0x300c → `hwint[2]=1` next cycle and ARM reads 0. W1C 0x04 → `hwint=0`. A second pass through 0x300c injects nothing.
